trap_control: RTL and testbench
===============================

// Module: trap_control
// PURPOSE
//  Multi-source machine-mode interrupt sequencer that owns the trap-entry path of the core FSM.
//  Samples NUM_IRQ level interrupt lines at instruction boundaries, prioritises them and latches
//  the winning cause. Then runs a fixed 3-cycle sequence: mepc <= pc, mcause <= cause,
//  pc <= direct or vectored mtvec target. The core FSM stalls fetch while busy is high.
// PARAMETERS
//  NUM_IRQ     4   number of interrupt lines (1..16)
//  XLEN        32  datapath width
//  VECTORED    1   1: honour mtvec.MODE=01 (vectored); 0: always direct
//  CAUSE_BASE  16  mcause exception code for irq[0]; irq[i] -> CAUSE_BASE+i
// PORTS
//  clk         in   1          core clock
//  reset_n     in   1          synchronous reset, active low
//  irq         in   NUM_IRQ    level-sensitive interrupt requests
//  irq_en      in   NUM_IRQ    per-source enable mask
//  mie         in   1          global machine interrupt enable
//  boundary    in   1          core FSM is at the fetch state (instruction boundary)
//  pc          in   XLEN       current PC (return address)
//  mtvec       in   XLEN       current mtvec CSR value
//  take        out  1          trap accepted this cycle (combinational); core must not fetch
//  busy        out  1          trap sequence in progress
//  mie_reset   out  1          clear global mie (pulse)
//  csr_we      out  1          CSR write strobe
//  csr_addr    out  12         CSR write address
//  csr_wdata   out  XLEN       CSR write data
//  pc_load     out  1          load pc from pc_next
//  pc_next     out  XLEN       trap handler address
// BEHAVIOUR
//  - Active low reset, synchronous (reset_n=0 at edge): state<=IDLE; cause_q, epc_q <= 0.
//    All outputs are 0 while reset_n=0 and in IDLE with no take.
//  - pend = irq & irq_en; winner = lowest set index of pend (index 0 highest priority).
//  - take = (state==IDLE) & boundary & mie & |pend. Pure combinational; mie_reset = take.
//  - On a take edge: cause_q <= CAUSE_BASE+winner, epc_q <= pc, state <= SAVE_EPC.
//  - SAVE_EPC:  csr_we=1, csr_addr=MEPC,   csr_wdata=epc_q; next WR_CAUSE.
//  - WR_CAUSE:  csr_we=1, csr_addr=MCAUSE, csr_wdata={1'b1, cause_q zero-ext to XLEN-1}; next VECTOR.
//  - VECTOR:    pc_load=1, pc_next=target; next IDLE.
//  - busy=1 in SAVE_EPC, WR_CAUSE and VECTOR; csr_addr, csr_wdata and pc_next are 0 when their strobe is low.
//  - target: base={mtvec[XLEN-1:2],2'b00}. If VECTORED & mtvec[1:0]==2'b01: base + (cause_q<<2),
//    modulo 2^XLEN. Otherwise base. mtvec[1:0] in {10,11} is treated as direct.
//  - Latency: take in cycle T; mepc written at edge T+1; mcause at T+2; pc loaded at T+3;
//    first handler fetch at boundary T+4 at the earliest.
//  - irq dropping or changing after take: no effect; cause_q and epc_q are frozen.
//  - boundary or irq during busy: ignored, no re-entry. mie is already 0 via mie_reset.
//  - Simultaneous pending lines: lowest index wins. Others stay pending and are re-evaluated
//    at the next boundary once the handler re-enables mie.
//  - mie=0 or boundary=0: take=0 regardless of irq.
//  - reset_n low mid-sequence: abort to IDLE next edge; no further csr_we or pc_load.
// STRUCTURE
//  - MEPC, MCAUSE and MTVEC CSR addresses and the IDLE/SAVE_EPC/WR_CAUSE/VECTOR state
//    encodings live in the shared defs.inc.
//  - One sub-module: prio_enc #(.N(NUM_IRQ)). Inputs: req[N-1:0]. Outputs: valid, idx[$clog2(N)-1:0],
//    where idx is the lowest-set index. It is purely combinational.
//  - Everything else (state register, cause/epc latches, output decode) stays in trap_control.
// TESTING
//  1. NUM_IRQ=4, mie=1, irq_en=4'hF, irq=4'b0100, boundary=1, pc=0x100, mtvec=0x200
//     -> take and mie_reset for 1 cycle; MEPC<=0x100, MCAUSE<=0x80000012; pc_load with pc_next=0x200.
//  2. Same stimulus with mtvec=0x201 -> pc_next=0x200+4*18=0x248.
//  3. irq=4'b1010, irq_en=4'b1000 -> cause 19. Then irq_en=4'hF, irq=4'b1010 -> cause 17 (lowest index wins).
//  4. irq drops the cycle after take, and boundary pulses during busy
//     -> sequence completes with the original cause; no second take.
//  5. mie=0 with irq=4'hF and boundary=1 for 10 cycles -> take, csr_we and pc_load never assert.
//  6. reset_n=0 in WR_CAUSE -> next cycle busy=0; no pc_load. Re-raise irq -> full sequence from SAVE_EPC.

Source files
------------

// File: rtl/trap_control_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses
// and the trap-entry state encoding.
package trap_control_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  // Trap-entry sequence: IDLE -> SAVE_EPC -> WR_CAUSE -> VECTOR -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE_EPC = 2'd1,
    ST_WR_CAUSE = 2'd2,
    ST_VECTOR   = 2'd3
  } trap_state_e;

endpackage

// File: rtl/trap_control_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req.
module prio_enc #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/trap_control.sv
// Machine-mode interrupt sequencer. Accepts an enabled interrupt at an
// instruction boundary, then spends three cycles writing mepc, mcause and
// loading the handler pc while fetch is stalled.
//
// Output timing: take/mie_reset are combinational in the accepting cycle.
// All other outputs are registered and reflect the current state, so a
// write strobe is high for exactly the cycle the FSM sits in the matching
// state; the data/address/pc_next buses are zero whenever their strobe is low.
module trap_control
  import trap_control_pkg::*;
#(
  parameter int NUM_IRQ    = 4,
  parameter int XLEN       = 32,
  parameter bit VECTORED   = 1'b1,
  parameter int CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mie,
  input  logic               boundary,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    mtvec,
  output logic               take,
  output logic               busy,
  output logic               mie_reset,
  output logic               csr_we,
  output logic [11:0]        csr_addr,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               pc_load,
  output logic [XLEN-1:0]    pc_next
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CW = XLEN - 1;

  logic [NUM_IRQ-1:0] pend;
  logic               pend_valid;
  logic [IW-1:0]      win_idx;

  trap_state_e        state_q, state_d;
  logic [CW-1:0]      cause_q, cause_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic               busy_q, busy_d;
  logic               csr_we_q, csr_we_d;
  logic [11:0]        csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]    csr_wdata_q, csr_wdata_d;
  logic               pc_load_q, pc_load_d;
  logic [XLEN-1:0]    pc_next_q, pc_next_d;

  logic [XLEN-1:0]    vec_base;
  logic [XLEN-1:0]    vec_target;

  assign pend = irq & irq_en;

  prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .req   (pend),
    .valid (pend_valid),
    .idx   (win_idx)
  );

  // Acceptance is only possible from IDLE; reset forces it low so every
  // output is quiet while reset_n is held.
  always_comb begin
    take      = reset_n && (state_q == ST_IDLE) && boundary && mie && pend_valid;
    mie_reset = take;
  end

  // Handler address: direct base, or base + 4*cause for vectored mode (wraps).
  always_comb begin
    vec_base   = {mtvec[XLEN-1:2], 2'b00};
    vec_target = vec_base;
    if (VECTORED && (mtvec[1:0] == 2'b01)) begin
      vec_target = vec_base + ({1'b0, cause_q} << 2);
    end
  end

  // Next state, frozen cause/epc latches and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    busy_d      = 1'b0;
    csr_we_d    = 1'b0;
    csr_addr_d  = '0;
    csr_wdata_d = '0;
    pc_load_d   = 1'b0;
    pc_next_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d     = ST_SAVE_EPC;
          cause_d     = CW'(CAUSE_BASE) + CW'(win_idx);
          epc_d       = pc;
          busy_d      = 1'b1;
          csr_we_d    = 1'b1;
          csr_addr_d  = CSR_MEPC;
          csr_wdata_d = pc;
        end
      end
      ST_SAVE_EPC: begin
        state_d     = ST_WR_CAUSE;
        busy_d      = 1'b1;
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MCAUSE;
        csr_wdata_d = {1'b1, cause_q};
      end
      ST_WR_CAUSE: begin
        state_d   = ST_VECTOR;
        busy_d    = 1'b1;
        pc_load_d = 1'b1;
        pc_next_d = vec_target;
      end
      ST_VECTOR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state/output register; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cause_q     <= '0;
      epc_q       <= '0;
      busy_q      <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      pc_load_q   <= 1'b0;
      pc_next_q   <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      busy_q      <= busy_d;
      csr_we_q    <= csr_we_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      pc_load_q   <= pc_load_d;
      pc_next_q   <= pc_next_d;
    end
  end

  assign busy      = busy_q;
  assign csr_we    = csr_we_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;

endmodule

// File: tb/tb_trap_control.sv
// Self-checking bench for trap_control (NUM_IRQ=4, XLEN=32, vectored, base 16).
module tb_trap_control;

  localparam logic [11:0] A_MEPC   = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  irq;
  logic [3:0]  irq_en;
  logic        mie;
  logic        boundary;
  logic [31:0] pc;
  logic [31:0] mtvec;
  logic        take, busy, mie_reset, csr_we, pc_load;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, pc_next;

  always #5 clk = ~clk;

  trap_control #(
    .NUM_IRQ(4), .XLEN(32), .VECTORED(1'b1), .CAUSE_BASE(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .irq_en(irq_en), .mie(mie),
    .boundary(boundary), .pc(pc), .mtvec(mtvec), .take(take), .busy(busy),
    .mie_reset(mie_reset), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .pc_load(pc_load), .pc_next(pc_next)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit mon_en   = 1'b0;
  logic [31:0] exp_q[$];
  logic [11:0] exp_addr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model: lowest pending index wins; -1 when nothing pending.
  function automatic int model_winner(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] tv, input int cause);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if (tv[1:0] == 2'b01) return base + 32'(cause * 4);
    return base;
  endfunction

  // Monitor: every CSR write and pc load must match the next expected item.
  always @(negedge clk) begin
    if (mon_en) begin
      if (csr_we) begin
        if (exp_addr_q.size() == 0) check("unexp_csr_we", {31'b0, csr_we}, 32'd0);
        else begin
          check("csr_addr", {20'b0, csr_addr}, {20'b0, exp_addr_q.pop_front()});
          check("csr_wdata", csr_wdata, exp_q.pop_front());
        end
      end else begin
        check("csr_bus_quiet", csr_wdata | {20'b0, csr_addr}, 32'd0);
      end
      if (pc_load) begin
        if (exp_q.size() == 0 || exp_addr_q.size() != 0)
          check("unexp_pc_load", {31'b0, pc_load}, 32'd0);
        else
          check("pc_next", pc_next, exp_q.pop_front());
      end else begin
        check("pc_next_quiet", pc_next, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one candidate; if accepted, follow the full sequence while
  // scrambling irq/boundary/pc to show the latched values stay frozen.
  task automatic run_seq(input logic [3:0] irq_v, input logic [3:0] en_v,
                         input logic [31:0] pc_v, input logic [31:0] tv_v,
                         input logic mie_v, input logic bnd_v, input bit abort);
    int   w;
    int   cause;
    logic exp_take;
    irq = irq_v; irq_en = en_v; pc = pc_v; mtvec = tv_v; mie = mie_v; boundary = bnd_v;
    w        = model_winner(irq_v & en_v);
    exp_take = mie_v && bnd_v && (w >= 0);
    @(negedge clk);
    check("take", {31'b0, take}, {31'b0, exp_take});
    check("mie_reset", {31'b0, mie_reset}, {31'b0, exp_take});
    check("busy_idle", {31'b0, busy}, 32'd0);
    if (!exp_take) begin
      tick;
      boundary = 1'b0;
      return;
    end
    cause = 16 + w;
    exp_addr_q.push_back(A_MEPC);   exp_q.push_back(pc_v);
    exp_addr_q.push_back(A_MCAUSE); exp_q.push_back(32'h8000_0000 | 32'(cause));
    if (!abort) exp_q.push_back(model_target(tv_v, cause));
    tick;
    pc = $urandom;
    for (int k = 0; k < 3; k++) begin
      irq      = 4'($urandom);
      boundary = 1'($urandom_range(0, 1));
      mie      = 1'b1;
      if (abort && k == 1) reset_n = 1'b0;
      @(negedge clk);
      check("busy_seq", {31'b0, busy}, 32'd1);
      check("take_busy", {31'b0, take}, 32'd0);
      tick;
      if (abort && k == 1) begin
        reset_n = 1'b1;
        break;
      end
    end
    boundary = 1'b0; mie = 1'b0; irq = 4'h0;
    @(negedge clk);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("pc_load_after", {31'b0, pc_load}, 32'd0);
    check("csr_we_after", {31'b0, csr_we}, 32'd0);
    tick;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; irq = 4'hF; irq_en = 4'hF; mie = 1'b1; boundary = 1'b1;
    pc = 32'h100; mtvec = 32'h200;
    tick; tick;
    @(negedge clk);
    check("rst_take", {31'b0, take}, 32'd0);
    check("rst_mie_reset", {31'b0, mie_reset}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_csr_we", {31'b0, csr_we}, 32'd0);
    check("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    check("rst_pc_load", {31'b0, pc_load}, 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    irq = 4'h0; mie = 1'b0; boundary = 1'b0;
    reset_n = 1'b1;
    tick;
    mon_en = 1'b1;

    // Direct and vectored targets, including reserved modes 10/11 as direct
    run_seq(4'b0100, 4'hF, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0);
    run_seq(4'b0100, 4'hF, 32'h100, 32'h201, 1'b1, 1'b1, 1'b0);
    run_seq(4'b0001, 4'hF, 32'h104, 32'h202, 1'b1, 1'b1, 1'b0);
    run_seq(4'b1000, 4'hF, 32'h108, 32'h303, 1'b1, 1'b1, 1'b0);
    // Enable mask and lowest-index priority
    run_seq(4'b1010, 4'b1000, 32'h2000, 32'h1001, 1'b1, 1'b1, 1'b0);
    run_seq(4'b1010, 4'hF,    32'h2004, 32'h1001, 1'b1, 1'b1, 1'b0);
    // Vectored wrap-around at the top of the address space
    run_seq(4'b0010, 4'hF, 32'h3000, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0);
    // No take without boundary or without pending-and-enabled
    run_seq(4'hF, 4'hF, 32'h40, 32'h200, 1'b1, 1'b0, 1'b0);
    run_seq(4'hF, 4'h0, 32'h40, 32'h200, 1'b1, 1'b1, 1'b0);

    // Global disable holds off everything for 10 cycles
    irq = 4'hF; irq_en = 4'hF; mie = 1'b0; boundary = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("mie0_take", {31'b0, take}, 32'd0);
      check("mie0_busy", {31'b0, busy}, 32'd0);
      tick;
    end
    boundary = 1'b0;

    // Reset during WR_CAUSE aborts; then a fresh full sequence
    run_seq(4'b0100, 4'hF, 32'h500, 32'h201, 1'b1, 1'b1, 1'b1);
    run_seq(4'b0100, 4'hF, 32'h504, 32'h201, 1'b1, 1'b1, 1'b0);

    // Randomized candidates
    for (int n = 0; n < 40; n++) begin
      run_seq(4'($urandom), 4'($urandom), $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    tick; tick;
    check("queue_empty", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
